// File: rtl/fwd_operand_stage_if.sv
// Operand-stage bus: pipeline control, register-file read ports, the two
// write-back forwarding sources and the registered ALU operand outputs.
interface fwd_operand_stage_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 16
);
    logic                        stall_i;
    logic                        flush_i;
    logic                        valid_i;
    logic [NUM_OPS*ADDR_W-1:0]   rs_addr_i;
    logic [NUM_OPS*DATA_W-1:0]   rs_data_i;
    logic                        exmem_we_i;
    logic [ADDR_W-1:0]           exmem_rd_i;
    logic [DATA_W-1:0]           exmem_data_i;
    logic                        memwb_we_i;
    logic [ADDR_W-1:0]           memwb_rd_i;
    logic [DATA_W-1:0]           memwb_data_i;
    logic [NUM_OPS*DATA_W-1:0]   op_data_o;
    logic [NUM_OPS*2-1:0]        fwd_sel_o;
    logic                        valid_o;
    logic [CNT_W-1:0]            fwd_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i, rs_addr_i, rs_data_i,
               exmem_we_i, exmem_rd_i, exmem_data_i,
               memwb_we_i, memwb_rd_i, memwb_data_i,
        input  op_data_o, fwd_sel_o, valid_o, fwd_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, rs_addr_i, rs_data_i,
               exmem_we_i, exmem_rd_i, exmem_data_i,
               memwb_we_i, memwb_rd_i, memwb_data_i,
        output op_data_o, fwd_sel_o, valid_o, fwd_cnt_o
    );
endinterface

// File: rtl/fwd_operand_stage.sv
// Forwarding operand stage: per-operand EX/MEM > MEM/WB > regfile select with
// r0 guard, one registered ALU operand stage with stall/flush, saturating count.
module fwd_operand_lane #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic              i_exmem_we,
    input  logic [ADDR_W-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_data,
    input  logic              i_memwb_we,
    input  logic [ADDR_W-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_data,
    output logic [1:0]        o_sel,
    output logic [DATA_W-1:0] o_data
);
    logic w_ex_hit;
    logic w_wb_hit;

    // r0 is hard-wired zero in the regfile, so a pending write to it never forwards
    assign w_ex_hit = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_rs_addr);
    assign w_wb_hit = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_rs_addr);

    always_comb begin
        o_sel  = 2'b00;
        o_data = i_rs_data;
        if (w_ex_hit) begin
            o_sel  = 2'b10;
            o_data = i_exmem_data;
        end else if (w_wb_hit) begin
            o_sel  = 2'b01;
            o_data = i_memwb_data;
        end
    end
endmodule

module fwd_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_OPS = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fwd_operand_stage_if.slave bus
);
    localparam int INC_W = $clog2(NUM_OPS + 1);

    logic [NUM_OPS-1:0][DATA_W-1:0] w_op_data;
    logic [NUM_OPS-1:0][1:0]        w_fwd_sel;
    logic [NUM_OPS-1:0][DATA_W-1:0] r_op_data;
    logic [NUM_OPS-1:0][1:0]        r_fwd_sel;
    logic                           r_valid;
    logic [CNT_W-1:0]               r_cnt;
    logic [INC_W-1:0]               w_inc;
    logic [CNT_W:0]                 w_cnt_sum;
    logic [CNT_W-1:0]               w_cnt_nxt;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_lane
        fwd_operand_lane #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .i_rs_addr    (bus.rs_addr_i[k*ADDR_W +: ADDR_W]),
            .i_rs_data    (bus.rs_data_i[k*DATA_W +: DATA_W]),
            .i_exmem_we   (bus.exmem_we_i),
            .i_exmem_rd   (bus.exmem_rd_i),
            .i_exmem_data (bus.exmem_data_i),
            .i_memwb_we   (bus.memwb_we_i),
            .i_memwb_rd   (bus.memwb_rd_i),
            .i_memwb_data (bus.memwb_data_i),
            .o_sel        (w_fwd_sel[k]),
            .o_data       (w_op_data[k])
        );
    end

    always_comb begin
        w_inc = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            w_inc = w_inc + INC_W'(|w_fwd_sel[k]);
        end
    end

    // One guard bit catches the carry; any overflow clamps to all-ones
    assign w_cnt_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);
    assign w_cnt_nxt = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op_data <= '0;
            r_fwd_sel <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.flush_i) begin
            r_op_data <= '0;
            r_fwd_sel <= '0;
            r_valid   <= 1'b0;
        end else if (!bus.stall_i) begin
            r_op_data <= w_op_data;
            r_fwd_sel <= w_fwd_sel;
            r_valid   <= bus.valid_i;
            if (bus.valid_i) begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign bus.op_data_o = r_op_data;
    assign bus.fwd_sel_o = r_fwd_sel;
    assign bus.valid_o   = r_valid;
    assign bus.fwd_cnt_o = r_cnt;
endmodule
